// File: rtl/mmm_exp_ctrl_if.sv
// Control bundle between the RSA register front-end, the exponentiation sequencer and
// the Montgomery multiplier/accumulator datapath.
interface mmm_exp_ctrl_if #(
    parameter int EXP_WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [EXP_WIDTH-1:0] E;
    logic                 busy;
    logic                 done;
    logic                 acc_init;
    logic                 acc_we;
    logic [1:0]           a_sel;
    logic [1:0]           b_sel;
    logic                 mmm_en;
    logic                 mmm_rst_n;
    logic                 mmm_ld_a;
    logic                 mmm_ld_r;
    logic                 mmm_lock;

    modport master (
        output start, abort, E,
        input  busy, done, acc_init, acc_we, a_sel, b_sel,
               mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock
    );

    modport slave (
        input  start, abort, E,
        output busy, done, acc_init, acc_we, a_sel, b_sel,
               mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock
    );
endinterface

// File: rtl/mmm_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a bit-serial Montgomery multiplier.
// Every output is a register decoded from the next state, so it lines up with the state it describes.
module mmm_exp_ctrl #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mmm_exp_ctrl_if.slave      bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, INIT, SQ, MUL, FIN} state_t;
    typedef enum logic [1:0] {CLR, LOAD, RUN, STORE} phase_t;

    state_t               state_reg, state_next;
    phase_t               phase_reg, phase_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [EXP_WIDTH-1:0] e_reg, e_next;
    logic                 done_next;
    logic                 op_next;

    logic       busy_reg, done_reg, acc_init_reg, acc_we_reg;
    logic [1:0] a_sel_reg, b_sel_reg;
    logic       mmm_en_reg, mmm_rst_n_reg, mmm_ld_a_reg, mmm_ld_r_reg, mmm_lock_reg;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        e_next     = e_reg;
        done_next  = 1'b0;
        if (bus.abort) begin
            state_next = IDLE;
            phase_next = CLR;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The done cycle sits in IDLE but does not accept a new request.
                    if (bus.start && !done_reg) begin
                        state_next = INIT;
                        e_next     = bus.E;
                        idx_next   = IDX_W'(EXP_WIDTH - 1);
                    end
                end
                INIT: begin
                    state_next = SQ;
                    phase_next = CLR;
                    cnt_next   = '0;
                end
                default: begin
                    case (phase_reg)
                        CLR:  phase_next = LOAD;
                        LOAD: begin
                            phase_next = RUN;
                            cnt_next   = '0;
                        end
                        RUN: begin
                            if (cnt_reg == CNT_W'(WIDTH - 1)) phase_next = STORE;
                            else                              cnt_next   = cnt_reg + CNT_W'(1);
                        end
                        default: begin
                            phase_next = CLR;
                            case (state_reg)
                                SQ: begin
                                    if (e_reg[idx_reg])    state_next = MUL;
                                    else if (idx_reg == '0) state_next = FIN;
                                    else begin
                                        state_next = SQ;
                                        idx_next   = idx_reg - IDX_W'(1);
                                    end
                                end
                                MUL: begin
                                    if (idx_reg == '0) state_next = FIN;
                                    else begin
                                        state_next = SQ;
                                        idx_next   = idx_reg - IDX_W'(1);
                                    end
                                end
                                default: begin
                                    state_next = IDLE;
                                    done_next  = 1'b1;
                                end
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign op_next = (state_next == SQ) || (state_next == MUL) || (state_next == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= CLR;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            e_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            acc_init_reg  <= 1'b0;
            acc_we_reg    <= 1'b0;
            a_sel_reg     <= 2'd0;
            b_sel_reg     <= 2'd0;
            mmm_en_reg    <= 1'b0;
            mmm_rst_n_reg <= 1'b1;
            mmm_ld_a_reg  <= 1'b0;
            mmm_ld_r_reg  <= 1'b0;
            mmm_lock_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            e_reg         <= e_next;
            busy_reg      <= (state_next != IDLE);
            done_reg      <= done_next;
            acc_init_reg  <= (state_next == INIT);
            acc_we_reg    <= op_next && (phase_next == STORE);
            a_sel_reg     <= (state_next == FIN) ? 2'd2 : 2'd0;
            b_sel_reg     <= (state_next == MUL) ? 2'd1 : 2'd0;
            mmm_en_reg    <= op_next && (phase_next != CLR);
            mmm_rst_n_reg <= !(op_next && (phase_next == CLR));
            mmm_ld_a_reg  <= op_next && (phase_next == LOAD);
            mmm_ld_r_reg  <= op_next && (phase_next == STORE);
            mmm_lock_reg  <= !(op_next && (phase_next == STORE));
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.acc_init  = acc_init_reg;
    assign bus.acc_we    = acc_we_reg;
    assign bus.a_sel     = a_sel_reg;
    assign bus.b_sel     = b_sel_reg;
    assign bus.mmm_en    = mmm_en_reg;
    assign bus.mmm_rst_n = mmm_rst_n_reg;
    assign bus.mmm_ld_a  = mmm_ld_a_reg;
    assign bus.mmm_ld_r  = mmm_ld_r_reg;
    assign bus.mmm_lock  = mmm_lock_reg;
endmodule

// File: tb/tb_mmm_exp_ctrl.sv
// Directed bench for mmm_exp_ctrl: full exponentiation schedules, ignored restarts,
// abort and reset mid-run, with counts and operation sequences checked per run.
module tb_mmm_exp_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mmm_exp_ctrl_if #(.EXP_WIDTH(8)) ifc ();

    mmm_exp_ctrl #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int          done_cyc, n_done, init_cyc, n_ld_a, n_we, n_bsel, n_fin, lock_bad, we_late;
    logic [63:0] op_seq;
    logic [12:0] snap;
    logic [12:0] outvec;
    logic [1:0]  code;

    assign outvec = {ifc.busy, ifc.done, ifc.acc_init, ifc.acc_we, ifc.a_sel, ifc.b_sel,
                     ifc.mmm_en, ifc.mmm_rst_n, ifc.mmm_ld_a, ifc.mmm_ld_r, ifc.mmm_lock};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issues one start (end of cycle 0) and samples cycles 1..last_c on the falling edge.
    // s1/s2: cycles with a stray start (E switched to 0xFF); ab_c: abort cycle; rs_c: rst cycle.
    task automatic run_seq(input logic [7:0] e_val, input int s1, input int s2,
                           input int ab_c, input int rs_c, input int last_c);
        done_cyc = -1; n_done = 0; init_cyc = -1; n_ld_a = 0; n_we = 0; n_bsel = 0;
        n_fin = 0; lock_bad = 0; we_late = 0; op_seq = '0; snap = '0;
        @(negedge clk);
        ifc.E     = e_val;
        ifc.start = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            if (ifc.acc_init && init_cyc < 0) init_cyc = c;
            if (ifc.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (ifc.mmm_ld_a) begin
                n_ld_a++;
                code   = (ifc.b_sel == 2'd1) ? 2'd1 : ((ifc.a_sel == 2'd2) ? 2'd2 : 2'd0);
                op_seq = {op_seq[61:0], code};
            end
            if (ifc.acc_we) begin
                n_we++;
                if ((ab_c > 0 && c > ab_c) || (rs_c > 0 && c > rs_c)) we_late++;
            end
            if (ifc.b_sel == 2'd1) n_bsel++;
            if (ifc.a_sel == 2'd2 && ifc.b_sel == 2'd0) n_fin++;
            if (ifc.mmm_lock !== ~ifc.acc_we || ifc.mmm_ld_r !== ifc.acc_we) lock_bad++;
            if ((ab_c > 0 && c == ab_c + 1) || (rs_c > 0 && c == rs_c + 1)) snap = outvec;
            ifc.start = (c == s1) || (c == s2);
            if (c == s1) ifc.E = 8'hFF;
            ifc.abort = (c == ab_c);
            rst       = (rs_c > 0 && c >= rs_c && c < rs_c + 3);
        end
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        ifc.E     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(outvec), 64'h009);
        rst = 1'b0;

        run_seq(8'h00, 0, 0, 0, 0, 104);
        $display("run E=00: done@%0d ld_a=%0d we=%0d seq=%0h", done_cyc, n_ld_a, n_we, op_seq);
        check("e00_init_cycle", 64'(init_cyc), 64'd1);
        check("e00_done_cycle", 64'(done_cyc), 64'd101);
        check("e00_done_count", 64'(n_done), 64'd1);
        check("e00_ld_a_count", 64'(n_ld_a), 64'd9);
        check("e00_we_count", 64'(n_we), 64'd9);
        check("e00_bsel_cycles", 64'(n_bsel), 64'd0);
        check("e00_op_seq", op_seq, 64'h2);

        run_seq(8'hFF, 0, 0, 0, 0, 192);
        $display("run E=FF: done@%0d bsel=%0d we=%0d seq=%0h", done_cyc, n_bsel, n_we, op_seq);
        check("eff_done_cycle", 64'(done_cyc), 64'd189);
        check("eff_bsel_cycles", 64'(n_bsel), 64'd88);
        check("eff_we_count", 64'(n_we), 64'd17);
        check("eff_op_seq", op_seq, 64'h44444446);

        run_seq(8'h80, 0, 0, 0, 0, 115);
        $display("run E=80: done@%0d fin=%0d lock_bad=%0d seq=%0h", done_cyc, n_fin, lock_bad, op_seq);
        check("e80_done_cycle", 64'(done_cyc), 64'd112);
        check("e80_op_seq", op_seq, 64'h10002);
        check("e80_fin_sel_cycles", 64'(n_fin), 64'd11);
        check("e80_lock_store_only", 64'(lock_bad), 64'd0);

        run_seq(8'h00, 5, 50, 0, 0, 104);
        $display("run restart-while-busy: done@%0d we=%0d seq=%0h", done_cyc, n_we, op_seq);
        check("busy_start_done_cycle", 64'(done_cyc), 64'd101);
        check("busy_start_op_seq", op_seq, 64'h2);
        check("busy_start_we_count", 64'(n_we), 64'd9);

        run_seq(8'hFF, 0, 0, 40, 0, 200);
        $display("run abort@40: we=%0d late_we=%0d dones=%0d snap=%0h", n_we, we_late, n_done, snap);
        check("abort_next_cycle", 64'({snap[12], snap[4], snap[0]}), 64'b001);
        check("abort_we_before", 64'(n_we), 64'd3);
        check("abort_we_after", 64'(we_late), 64'd0);
        check("abort_no_done", 64'(n_done), 64'd0);

        run_seq(8'h80, 0, 0, 0, 0, 115);
        $display("run after abort E=80: done@%0d seq=%0h", done_cyc, op_seq);
        check("post_abort_done_cycle", 64'(done_cyc), 64'd112);
        check("post_abort_op_seq", op_seq, 64'h10002);

        run_seq(8'hFF, 0, 0, 0, 60, 200);
        $display("run rst@60: snap=%0h late_we=%0d dones=%0d", snap, we_late, n_done);
        check("rst_outputs", 64'(snap), 64'h009);
        check("rst_no_done", 64'(n_done), 64'd0);
        check("rst_no_we_after", 64'(we_late), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmm_exp_ctrl.md
# mmm_exp_ctrl

Sequencer that drives the bit-serial Montgomery multiplier through a full left-to-right square-and-multiply modular exponentiation. It latches the exponent on a start handshake and schedules every multiplier operation: clear, operand load, WIDTH serial iterations, result capture. It also steers the datapath operand multiplexers and the accumulator write strobe. It sits between the RSA top-level register interface and the multiplier/accumulator datapath. It contains no arithmetic.

## Interface
- WIDTH, 8: multiplier operand width; one operation runs WIDTH serial iterations.
- EXP_WIDTH, 8: exponent width; all EXP_WIDTH bits are processed, MSB first.
- clk  in  1  clock; everything is sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE; E is latched on that edge.
- abort  in  1  synchronous abort; returns to IDLE next edge; no done.
- E  in  EXP_WIDTH  exponent.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse after the final capture.
- acc_init  out  1  accumulator loads the external Montgomery-one value.
- acc_we  out  1  accumulator captures the multiplier result R.
- a_sel  out  2  multiplier A source: 0 = accumulator, 1 = base (Montgomery form), 2 = constant 1.
- b_sel  out  2  multiplier B source: 0 = accumulator, 1 = base.
- mmm_en  out  1  multiplier enable.
- mmm_rst_n  out  1  multiplier internal clear, active-low.
- mmm_ld_a  out  1  loads A into the multiplier shift register.
- mmm_ld_r  out  1  loads the result register.
- mmm_lock  out  1  freezes the multiplier result register while high.

## Operation
- Top-level states: IDLE, INIT, SQ, MUL, FIN. Each of SQ, MUL and FIN is one multiplier operation.
- Sub-phases of every operation, WIDTH+3 cycles in total:
  - CLR (1 cycle): mmm_rst_n=0, mmm_en=0.
  - LOAD (1 cycle): mmm_en=1, mmm_ld_a=1.
  - RUN (WIDTH cycles): mmm_en=1. An iteration counter counts 0..WIDTH-1.
  - STORE (1 cycle): mmm_en=1, mmm_ld_r=1, mmm_lock=0, acc_we=1.
- Operand selects per operation:
  - SQ: a_sel=0, b_sel=0.
  - MUL: a_sel=0, b_sel=1.
  - FIN: a_sel=2, b_sel=0; this converts the result out of the Montgomery domain.
- a_sel/b_sel are constant over all WIDTH+3 cycles of an operation. In IDLE and INIT both are 0.
- Flow:
  - IDLE goes to INIT when start=1. E is latched into e_reg and bit index i=EXP_WIDTH-1.
  - INIT lasts 1 cycle with acc_init=1, then goes to SQ.
  - After SQ: if e_reg[i]=1, go to MUL. Otherwise, if i=0 go to FIN, else decrement i and go to SQ.
  - After MUL: if i=0 go to FIN, else decrement i and go to SQ.
  - After FIN: done=1 for one cycle and return to IDLE. busy is low in that done cycle.
- Idle/default output values: mmm_rst_n=1, mmm_lock=1; every other strobe is 0.
- Each strobe (acc_init, acc_we, mmm_ld_a, mmm_ld_r, done) is high for exactly one cycle per event.
- start while busy is ignored; e_reg does not change.
- Changes on E after acceptance have no effect.
- E=0 still performs EXP_WIDTH squarings and then FIN.

## Timing
- All outputs are registered.
- Reset values:
  - busy=0, done=0, acc_init=0, acc_we=0.
  - a_sel=0, b_sel=0.
  - mmm_en=0, mmm_rst_n=1, mmm_ld_a=0, mmm_ld_r=0, mmm_lock=1.
- Reset or abort mid-operation: the next cycle shows the reset/idle values, with no acc_we and no done.
- rst takes priority over abort; abort takes priority over start.
- Cycle numbering: the edge accepting start is the end of cycle 0.
  - INIT occupies cycle 1.
  - Operations follow back-to-back with no gaps, starting at cycle 2.
- Latency with p = popcount(E) and N = (EXP_WIDTH+p+1)·(WIDTH+3):
  - The last STORE is in cycle 1+N.
  - done is in cycle 2+N.
  - A new start is accepted in cycle 3+N.
- Counters are sized as clog2(WIDTH) and clog2(EXP_WIDTH). The bit index must not wrap below 0.

## Test plan
All cases use WIDTH=8, EXP_WIDTH=8.
- E=0x00, start pulse:
  - acc_init in cycle 1.
  - 8 SQ operations, then 1 FIN, each 11 cycles.
  - done in cycle 101 only; exactly 9 mmm_ld_a pulses and 9 acc_we pulses.
- E=0xFF: 16 alternating SQ/MUL operations, then FIN; done in cycle 189; b_sel=1 for exactly 8·11 cycles.
- E=0x80:
  - Operation sequence SQ, MUL, SQ×7, FIN; done in cycle 112.
  - FIN operation has a_sel=2, b_sel=0.
  - mmm_lock is low only in the STORE cycles.
- start re-asserted while busy (cycles 5 and 50) with E changed to 0xFF: timing identical to the E=0x00 case; done in cycle 101.
- abort in cycle 40 (mid-RUN):
  - The next cycle shows busy=0, mmm_en=0, mmm_lock=1.
  - No acc_we and no done afterwards.
  - A subsequent start runs a full, correct sequence.
- rst asserted in cycle 60 during an E=0xFF run: all outputs hold their reset values from the next cycle; no done while rst is high or afterwards without a new start.
